// File: rtl/tx_gearbox_6664_pkg.sv
// Shared constants, types and the block/leftover composer for the 66b->64b TX gearbox.
// One 33-cycle sequence packs 32 blocks of 66 bits into 33 words of 64 bits.
package tx_gearbox_6664_pkg;

  localparam int unsigned GB_SEQ_LEN   = 33;
  localparam int unsigned GB_BLOCK_W   = 66;
  localparam int unsigned GB_PAYLOAD_W = 64;
  localparam int unsigned GB_HEADER_W  = 2;
  localparam int unsigned GB_WORD_W    = 64;

  typedef logic [5:0] gb_seq_t;

  localparam gb_seq_t GB_PAUSE_SEQ = 6'd32;

  typedef enum logic {
    GB_PHASE_BLOCK,
    GB_PHASE_PAUSE
  } gb_phase_t;

  // Leftover bits above 2*seq are held at zero, so a plain OR merges them.
  function automatic logic [127:0] gb_compose(
    input logic [GB_BLOCK_W-1:0] blk,
    input logic [GB_WORD_W-1:0]  leftover,
    input gb_seq_t               seq
  );
    logic [6:0] shamt;
    shamt = {1'b0, seq[4:0], 1'b0};
    return ({62'b0, blk} << shamt) | {64'b0, leftover};
  endfunction

endpackage

// File: rtl/tx_gearbox_6664_if.sv
// Block-in / word-out bundle between the scrambler, the gearbox and the serializer.
interface tx_gearbox_6664_if;
  import tx_gearbox_6664_pkg::*;

  logic [GB_PAYLOAD_W-1:0] i_txd;
  logic [GB_HEADER_W-1:0]  i_tx_header;
  logic [GB_WORD_W-1:0]    o_txd;
  logic                    o_tx_pause;

  modport master (
    output i_txd,
    output i_tx_header,
    input  o_txd,
    input  o_tx_pause
  );

  modport slave (
    input  i_txd,
    input  i_tx_header,
    output o_txd,
    output o_tx_pause
  );

endinterface

// File: rtl/tx_gearbox_6664.sv
// 64b/66b TX gearbox: one 66-bit block per cycle in, continuous 64-bit words out,
// with a one-cycle pause every 33 cycles while the accumulated leftover drains.
module tx_gearbox_6664
  import tx_gearbox_6664_pkg::*;
(
  input  logic                 i_txc,
  input  logic                 i_reset_n,
  tx_gearbox_6664_if.slave     gb
);

  gb_seq_t                seq;
  logic [GB_WORD_W-1:0]   leftover;
  logic [GB_WORD_W-1:0]   txd_q;
  logic [127:0]           cat;
  gb_phase_t              phase;

  // Pause is decoded from the registered sequence count only, never from inputs.
  always_comb begin
    phase = GB_PHASE_BLOCK;
    if (seq == GB_PAUSE_SEQ) begin
      phase = GB_PHASE_PAUSE;
    end
  end

  always_comb begin
    cat = '0;
    cat = gb_compose({gb.i_txd, gb.i_tx_header}, leftover, seq);
  end

  always_ff @(posedge i_txc or negedge i_reset_n) begin
    if (!i_reset_n) begin
      seq      <= '0;
      leftover <= '0;
      txd_q    <= '0;
    end else if (phase == GB_PHASE_PAUSE) begin
      txd_q    <= leftover;
      leftover <= '0;
      seq      <= '0;
    end else begin
      txd_q    <= cat[63:0];
      leftover <= cat[127:64];
      seq      <= seq + 6'd1;
    end
  end

  assign gb.o_txd      = txd_q;
  assign gb.o_tx_pause = (phase == GB_PHASE_PAUSE);

endmodule
